// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Pure declarations: no latency, no flow control.
package clk_div_pkg;

    localparam int DIV_MIN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int unsigned half(input int unsigned n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable divider; master drives divisor and enable.
// No handshake: div_load is a single-cycle strobe, outputs are level/pulse.
interface clk_div_prog_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             div_err;
    logic             period_tick;

    modport master (
        output en, div_val, div_load,
        input  clk_out, div_err, period_tick
    );

    modport slave (
        input  en, div_val, div_load,
        output clk_out, div_err, period_tick
    );
endinterface

// File: rtl/clk_div_core.sv
// Period counter plus posedge/negedge phase regs producing a 50% duty divided clock.
// clk_out rises one posedge after i_restart; no backpressure.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_run,
    input  logic             i_restart,
    output logic             o_last,
    output logic             o_clk
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_p;
    logic             r_n;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_half    = CNT_W'(half(32'(i_div)));
    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    assign o_last    = (r_cnt == (i_div - CNT_W'(1)));

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_p   <= 1'b0;
        end else if (i_restart) begin
            r_cnt <= '0;
            r_p   <= 1'b1;
        end else if (i_run && !o_last) begin
            r_cnt <= w_cnt_nxt;
            r_p   <= (w_cnt_nxt < w_half);
        end else begin
            r_cnt <= '0;
            r_p   <= 1'b0;
        end
    end

    // Half-cycle delayed copy stretches the high phase by 0.5 cycle for odd divisors.
    always_ff @(negedge clk_in or negedge rst) begin
        if (!rst) begin
            r_n <= 1'b0;
        end else begin
            r_n <= r_p;
        end
    end

    // i_div only changes at a period boundary, where both phase regs are low.
    assign o_clk = i_div[0] ? (r_p | r_n) : r_p;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50% duty divider; divisor changes only at period boundaries.
// clk_out starts one posedge after en; period_tick only with CLK_DIV_PERIOD_TICK_EN.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 7
) (
    input  logic          clk_in,
    input  logic          rst,
    clk_div_prog_if.slave bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_shd;
    logic             r_err;
    logic             w_last;
    logic             w_boundary;
    logic             w_restart;
    logic             w_clk;

    assign w_boundary = (r_state == RUN) && w_last;

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_state_nxt = RUN;
                    w_restart   = 1'b1;
                end
            end
            RUN: begin
                if (w_boundary) begin
                    if (bus.en) begin
                        w_restart = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shadow is promoted with its pre-edge value, so a load on the boundary waits a period.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_div_act <= CNT_W'(DIV_DEFAULT);
            r_div_shd <= CNT_W'(DIV_DEFAULT);
            r_err     <= 1'b0;
        end else begin
            if (bus.div_load) begin
                if (bus.div_val < CNT_W'(DIV_MIN)) begin
                    r_div_shd <= CNT_W'(DIV_MIN);
                    r_err     <= 1'b1;
                end else begin
                    r_div_shd <= bus.div_val;
                end
            end
            if ((r_state == IDLE) || w_boundary) begin
                r_div_act <= r_div_shd;
            end
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_in    (clk_in),
        .rst       (rst),
        .i_div     (r_div_act),
        .i_run     (r_state == RUN),
        .i_restart (w_restart),
        .o_last    (w_last),
        .o_clk     (w_clk)
    );

    assign bus.clk_out = w_clk;
    assign bus.div_err = r_err;

`ifdef CLK_DIV_PERIOD_TICK_EN
    logic r_tick;

    // A restart edge is exactly the edge that lands the counter on 0 in RUN.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_restart;
        end
    end

    assign bus.period_tick = r_tick;
`else
    assign bus.period_tick = 1'b0;
`endif

endmodule
